pixel_writer: RTL and testbench
===============================

PIXEL_WRITER -- requirements
Module: pixel_writer

Interface
REQ-001 SHALL have parameter H_RES, default 640, horizontal pixel count and row stride.
REQ-002 SHALL have parameter V_RES, default 480, vertical pixel count.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, pixel buffer entries (power of two, >=2).
REQ-004 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-005 SHALL have port n_rst, input, 1, reset, asynchronous and active-low.
REQ-006 SHALL have port address, input, 19, pixel coordinate {x[18:9], y[8:0]} from the rasterizer.
REQ-007 SHALL have port pixel_valid, input, 1, address carries a pixel this cycle.
REQ-008 SHALL have port color, input, 8, pixel color, sampled with address.
REQ-009 SHALL have port prim_done, input, 1, one-cycle pulse: rasterizer finished the primitive.
REQ-010 SHALL have port stop, output, 1, backpressure to the rasterizer.
REQ-011 SHALL have port mem_addr, output, 19, linear frame-buffer address.
REQ-012 SHALL have port mem_wdata, output, 8, write data.
REQ-013 SHALL have port mem_we, output, 1, write request, held until acknowledged.
REQ-014 SHALL have port mem_ack, input, 1, memory accepted the write this cycle.
REQ-015 SHALL have port frame_done, output, 1, one-cycle pulse: primitive fully written.

Function
REQ-016 SHALL push {address, color} into the FIFO on every clk edge with pixel_valid=1 and FIFO not full.
REQ-017 SHALL assert stop combinationally when occupancy >= FIFO_DEPTH-1, giving one cycle of slack for a pixel already in flight.
REQ-018 SHALL drop a pixel arriving while full and set an internal sticky overflow flag, visible in simulation only.
REQ-019 SHALL run FSM states IDLE, LOAD, WRITE, DRAIN.
REQ-020 IDLE: FIFO non-empty -> LOAD; prim_done=1 with FIFO empty -> frame_done pulse next cycle, stay IDLE.
REQ-021 LOAD: pop head, register mem_addr = y*H_RES + x (19-bit, truncating), mem_wdata = color -> WRITE next cycle.
REQ-022 WRITE: mem_we=1 with mem_addr and mem_wdata stable until the mem_ack cycle; on ack: FIFO non-empty -> LOAD, else done latched -> DRAIN, else -> IDLE.
REQ-023 DRAIN: pulse frame_done for one cycle -> IDLE.
REQ-024 SHALL latch prim_done into a pending-done flag cleared on the frame_done pulse; frame_done fires only after every pixel accepted before prim_done has been acked.
REQ-025 Push and pop in the same cycle SHALL leave occupancy unchanged; pointers wrap modulo FIFO_DEPTH.
REQ-026 mem_ack outside WRITE SHALL be ignored.
REQ-027 Minimum throughput SHALL be one pixel per two cycles with mem_ack asserted on the first mem_we cycle.

Reset
REQ-028 On n_rst=0, asynchronously: state IDLE, FIFO empty, pointers 0, pending-done 0, stop 0, mem_we 0, mem_addr 0, mem_wdata 0, frame_done 0.
REQ-029 Reset during WRITE SHALL drop mem_we immediately and discard all buffered pixels.

Configuration
REQ-030 With PIXEL_CLIP_EN defined, LOAD SHALL discard a pixel with x>=H_RES or y>=V_RES, with no mem_we, and proceed as if acked.
REQ-031 Without PIXEL_CLIP_EN, every popped pixel SHALL be written, with the address truncated to 19 bits.

Verification
REQ-032 Single pixel: address={10'd5,9'd2}, color=8'hAA, pixel_valid one cycle, mem_ack tied 1 -> mem_we with mem_addr=1285, mem_wdata=8'hAA, exactly one cycle.
REQ-033 Backpressure: mem_ack=0, push 3 pixels -> stop=1 after the third push; a fourth push is accepted; a fifth is dropped with overflow set.
REQ-034 Done ordering: push 2 pixels, pulse prim_done, ack each after 3 cycles -> frame_done one cycle after the second ack, never earlier.
REQ-035 Clip: with PIXEL_CLIP_EN, pixel x=700, y=10 -> no mem_we; without it -> mem_we, mem_addr=(10*640+700) mod 2^19=7100.
REQ-036 Reset mid-write: n_rst low while mem_we=1 -> mem_we=0 same cycle, stop=0; after release, FIFO empty and state IDLE.

Source files
------------

// File: rtl/pixel_writer.sv
// pixel_writer
// Buffers rasterizer pixels in a small FIFO and writes each one to a linear
// frame buffer. The write address is y*H_RES + x, truncated to 19 bits. Each
// write is a request/acknowledge handshake. Once every pixel accepted before
// prim_done has been written, the block pulses frame_done.
//
// Ports
//   clk          single clock, rising edge
//   n_rst        asynchronous active-low reset
//   address      {x[18:9], y[8:0]} pixel coordinate
//   pixel_valid  address/color carry a pixel this cycle
//   color        8-bit pixel color
//   prim_done    one-cycle pulse, primitive finished by the rasterizer
//   stop         backpressure, high when occupancy >= FIFO_DEPTH-1
//   mem_addr     linear frame-buffer address (registered)
//   mem_wdata    write data (registered)
//   mem_we       write request, held until mem_ack
//   mem_ack      memory accepted the write this cycle
//   frame_done   one-cycle pulse, primitive fully written
//
// Configuration macro
//   PIXEL_CLIP_EN  when defined, pixels with x>=H_RES or y>=V_RES are
//                  discarded at LOAD without a memory write.
module pixel_writer #(
  parameter int H_RES      = 640,
  parameter int V_RES      = 480,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic [18:0] address,
  input  logic        pixel_valid,
  input  logic [7:0]  color,
  input  logic        prim_done,
  output logic        stop,
  output logic [18:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  input  logic        mem_ack,
  output logic        frame_done
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_STOP = CNT_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [31:0]      X_LIMIT  = 32'(H_RES);
  localparam logic [31:0]      Y_LIMIT  = 32'(V_RES);
  localparam logic [18:0]      STRIDE   = 19'(H_RES);
`ifdef PIXEL_CLIP_EN
  localparam logic CLIP_EN = 1'b1;
`else
  localparam logic CLIP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [26:0]      r_fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_done_pend;
  logic             r_overflow;
  logic             r_mem_we;
  logic [18:0]      r_mem_addr;
  logic [7:0]       r_mem_wdata;
  logic             r_frame_done;

  logic        w_full;
  logic        w_empty;
  logic        w_push;
  logic        w_pop;
  logic [26:0] w_head;
  logic [9:0]  w_head_x;
  logic [8:0]  w_head_y;
  logic [7:0]  w_head_color;
  logic [18:0] w_lin_addr;
  logic        w_out_of_range;
  logic        w_clip;
  logic        w_done_any;
  logic        w_fire;
  logic        w_unused_overflow;

  assign w_full  = (r_count == CNT_FULL);
  assign w_empty = (r_count == {CNT_W{1'b0}});
  assign w_push  = pixel_valid & ~w_full;
  // LOAD is only entered with at least one entry buffered, so popping is safe.
  assign w_pop   = (r_state == ST_LOAD);

  assign w_head       = r_fifo_mem[r_rd_ptr];
  assign w_head_x     = w_head[26:17];
  assign w_head_y     = w_head[16:8];
  assign w_head_color = w_head[7:0];
  // The product and the sum are both taken at 19 bits, so they wrap modulo 2^19.
  assign w_lin_addr   = {10'd0, w_head_y} * STRIDE + {9'd0, w_head_x};

  assign w_out_of_range = ({22'd0, w_head_x} >= X_LIMIT) || ({23'd0, w_head_y} >= Y_LIMIT);
  assign w_clip         = CLIP_EN & w_out_of_range;

  // A prim_done arriving in the same cycle as the last ack still counts.
  assign w_done_any = r_done_pend | prim_done;
  assign w_fire     = (w_next_state == ST_DRAIN) ||
                      ((r_state == ST_IDLE) && w_empty && w_done_any);

  // Stop asserts one entry early, so a pixel already in flight still has a slot.
  assign stop       = (r_count >= CNT_STOP);
  assign mem_we     = r_mem_we;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign frame_done = r_frame_done;

  // The overflow flag is only inspected from simulation. This sink keeps it read.
  assign w_unused_overflow = r_overflow;

  // FIFO storage: data needs no reset because the pointers gate every read.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_mem[r_wr_ptr] <= {address, color};
    end
  end

  // FIFO pointers, occupancy and the sticky overflow flag.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_wr_ptr   <= {PTR_W{1'b0}};
      r_rd_ptr   <= {PTR_W{1'b0}};
      r_count    <= {CNT_W{1'b0}};
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end else begin
        r_wr_ptr <= r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end else begin
        r_rd_ptr <= r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
      if (pixel_valid && w_full) begin
        r_overflow <= 1'b1;
      end else begin
        r_overflow <= r_overflow;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_next_state = ST_LOAD;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_LOAD: begin
        // A clipped pixel behaves like an immediately acked write. The head is
        // leaving this cycle, so another pixel is waiting only if count > 1.
        if (w_clip) begin
          if (r_count > CNT_ONE) begin
            w_next_state = ST_LOAD;
          end else if (w_done_any) begin
            w_next_state = ST_DRAIN;
          end else begin
            w_next_state = ST_IDLE;
          end
        end else begin
          w_next_state = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (mem_ack) begin
          if (!w_empty) begin
            w_next_state = ST_LOAD;
          end else if (w_done_any) begin
            w_next_state = ST_DRAIN;
          end else begin
            w_next_state = ST_IDLE;
          end
        end else begin
          w_next_state = ST_WRITE;
        end
      end
      ST_DRAIN: begin
        w_next_state = ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // Registered memory interface, frame_done pulse and pending-done flag.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_mem_we     <= 1'b0;
      r_mem_addr   <= 19'd0;
      r_mem_wdata  <= 8'd0;
      r_frame_done <= 1'b0;
      r_done_pend  <= 1'b0;
    end else begin
      r_mem_we     <= (w_next_state == ST_WRITE);
      r_frame_done <= w_fire;
      if (r_state == ST_LOAD) begin
        r_mem_addr  <= w_lin_addr;
        r_mem_wdata <= w_head_color;
      end else begin
        r_mem_addr  <= r_mem_addr;
        r_mem_wdata <= r_mem_wdata;
      end
      if (w_fire) begin
        r_done_pend <= 1'b0;
      end else if (prim_done) begin
        r_done_pend <= 1'b1;
      end else begin
        r_done_pend <= r_done_pend;
      end
    end
  end

endmodule

// File: tb/tb_pixel_writer.sv
// Scoreboard testbench for pixel_writer. Expected writes are queued when a
// pixel is driven and are checked when mem_we rises. The bench follows the
// PIXEL_CLIP_EN define in the same way as the design.
module tb_pixel_writer;

  logic        clk = 1'b0;
  logic        n_rst;
  logic [18:0] address;
  logic        pixel_valid;
  logic [7:0]  color;
  logic        prim_done;
  logic        stop;
  logic [18:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic        mem_ack;
  logic        frame_done;

`ifdef PIXEL_CLIP_EN
  localparam bit CLIP_ON = 1'b1;
`else
  localparam bit CLIP_ON = 1'b0;
`endif

  typedef struct packed {
    logic [18:0] a;
    logic [7:0]  d;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  pixel_writer dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .address     (address),
    .pixel_valid (pixel_valid),
    .color       (color),
    .prim_done   (prim_done),
    .stop        (stop),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_we      (mem_we),
    .mem_ack     (mem_ack),
    .frame_done  (frame_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [18:0] lin(input int x, input int y);
    int v;
    v = y * 640 + x;
    return v[18:0];
  endfunction

  task automatic drive_pixel(input int x, input int y, input logic [7:0] c, input bit keep);
    exp_t e;
    address     = {10'(x), 9'(y)};
    color       = c;
    pixel_valid = 1'b1;
    e.a = lin(x, y);
    e.d = c;
    if (keep) sb.push_back(e);
    tick();
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    tick(); tick();
    total++; if (stop !== 1'b0) begin bad++; $display("FAIL rst_stop: got %b want 0", stop); end
    total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL rst_we: got %b want 0", mem_we); end
    total++; if (mem_addr !== 19'd0) begin bad++; $display("FAIL rst_addr: got %0d want 0", mem_addr); end
    total++; if (mem_wdata !== 8'd0) begin bad++; $display("FAIL rst_wdata: got %h want 00", mem_wdata); end
    total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL rst_fd: got %b want 0", frame_done); end
    n_rst = 1'b1;
    tick();
  endtask

  task automatic test_single();
    exp_t e;
    logic prev;
    int   we_cycles;
    mem_ack = 1'b1;
    drive_pixel(5, 2, 8'hAA, 1'b1);
    pixel_valid = 1'b0;
    prev = 1'b0;
    we_cycles = 0;
    for (int k = 0; k < 10; k++) begin
      if (mem_we === 1'b1) we_cycles++;
      if (mem_we === 1'b1 && !prev) begin
        total++;
        if (sb.size() == 0) begin bad++; $display("FAIL single_extra: got write addr %0d want none", mem_addr); end
        else begin
          e = sb.pop_front();
          total++; if (mem_addr !== e.a) begin bad++; $display("FAIL single_addr: got %0d want %0d", mem_addr, e.a); end
          total++; if (mem_wdata !== e.d) begin bad++; $display("FAIL single_data: got %h want %h", mem_wdata, e.d); end
        end
      end
      prev = mem_we;
      tick();
    end
    total++; if (we_cycles != 1) begin bad++; $display("FAIL single_we_len: got %0d want 1", we_cycles); end
    total++; if (sb.size() != 0) begin bad++; $display("FAIL single_left: got %0d want 0", sb.size()); end
  endtask

  task automatic test_idle_done();
    prim_done = 1'b1;
    tick();
    prim_done = 1'b0;
    total++; if (frame_done !== 1'b1) begin bad++; $display("FAIL idle_fd: got %b want 1", frame_done); end
    tick();
    total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL idle_fd_len: got %b want 0", frame_done); end
  endtask

  task automatic test_backpressure();
    exp_t e;
    exp_t p0;
    logic prev;
    int   nwr;
    mem_ack = 1'b0;
    drive_pixel(10, 3, 8'h10, 1'b1);
    p0 = sb[0];
    pixel_valid = 1'b0;
    tick(); tick();
    total++; if (mem_we !== 1'b1) begin bad++; $display("FAIL bp_we: got %b want 1", mem_we); end
    e = sb.pop_front();
    total++; if (mem_addr !== e.a) begin bad++; $display("FAIL bp_first_addr: got %0d want %0d", mem_addr, e.a); end
    for (int i = 1; i <= 5; i++) begin
      drive_pixel(10 + 37 * i, 3 + 11 * i, 8'(16 + i), (i <= 4));
      if (i == 2) begin
        total++; if (stop !== 1'b0) begin bad++; $display("FAIL bp_stop_two: got %b want 0", stop); end
      end
      if (i == 3) begin
        total++; if (stop !== 1'b1) begin bad++; $display("FAIL bp_stop_three: got %b want 1", stop); end
      end
      if (i == 4) begin
        total++; if (stop !== 1'b1) begin bad++; $display("FAIL bp_stop_four: got %b want 1", stop); end
        total++; if (dut.r_overflow !== 1'b0) begin bad++; $display("FAIL bp_ovf_early: got %b want 0", dut.r_overflow); end
      end
      if (i == 5) begin
        total++; if (dut.r_overflow !== 1'b1) begin bad++; $display("FAIL bp_ovf: got %b want 1", dut.r_overflow); end
      end
    end
    pixel_valid = 1'b0;
    total++; if (mem_addr !== p0.a) begin bad++; $display("FAIL bp_addr_held: got %0d want %0d", mem_addr, p0.a); end
    mem_ack = 1'b1;
    prev = mem_we;
    nwr = 0;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (mem_we === 1'b1 && !prev) begin
        nwr++;
        total++;
        if (sb.size() == 0) begin bad++; $display("FAIL bp_extra: got write addr %0d want none", mem_addr); end
        else begin
          e = sb.pop_front();
          total++; if (mem_addr !== e.a) begin bad++; $display("FAIL bp_addr: got %0d want %0d", mem_addr, e.a); end
          total++; if (mem_wdata !== e.d) begin bad++; $display("FAIL bp_data: got %h want %h", mem_wdata, e.d); end
        end
      end
      prev = mem_we;
    end
    total++; if (nwr != 4) begin bad++; $display("FAIL bp_count: got %0d want 4", nwr); end
    total++; if (sb.size() != 0) begin bad++; $display("FAIL bp_left: got %0d want 0", sb.size()); end
    total++; if (stop !== 1'b0) begin bad++; $display("FAIL bp_stop_end: got %b want 0", stop); end
  endtask

  task automatic test_done_order();
    exp_t cur;
    logic prev;
    logic ack_now;
    logic exp_fd;
    int   wcnt;
    int   acks;
    int   fd;
    mem_ack = 1'b0;
    drive_pixel(100, 40, 8'h3C, 1'b1);
    drive_pixel(200, 77, 8'hC3, 1'b1);
    pixel_valid = 1'b0;
    prim_done = 1'b1;
    tick();
    prim_done = 1'b0;
    prev = 1'b0;
    wcnt = 0;
    acks = 0;
    fd   = 0;
    cur  = '0;
    for (int k = 0; k < 40; k++) begin
      if (mem_we === 1'b1) begin
        if (!prev) begin
          wcnt = 1;
          total++;
          if (sb.size() == 0) begin bad++; $display("FAIL done_extra: got write addr %0d want none", mem_addr); end
          else cur = sb.pop_front();
        end else begin
          wcnt++;
        end
        total++; if (mem_addr !== cur.a) begin bad++; $display("FAIL done_addr_stable: got %0d want %0d", mem_addr, cur.a); end
        total++; if (mem_wdata !== cur.d) begin bad++; $display("FAIL done_data_stable: got %h want %h", mem_wdata, cur.d); end
      end
      prev    = mem_we;
      mem_ack = (mem_we === 1'b1) && (wcnt == 3);
      ack_now = mem_ack;
      tick();
      if (ack_now) acks++;
      exp_fd = ack_now && (acks == 2);
      total++; if (frame_done !== exp_fd) begin bad++; $display("FAIL done_fd_k%0d: got %b want %b", k, frame_done, exp_fd); end
      if (frame_done === 1'b1) fd++;
    end
    mem_ack = 1'b0;
    total++; if (acks != 2) begin bad++; $display("FAIL done_acks: got %0d want 2", acks); end
    total++; if (fd != 1) begin bad++; $display("FAIL done_fd_count: got %0d want 1", fd); end
    total++; if (sb.size() != 0) begin bad++; $display("FAIL done_left: got %0d want 0", sb.size()); end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic prev;
    int   last;
    int   nwr;
    mem_ack = 1'b1;
    prev = 1'b0;
    last = -1;
    nwr  = 0;
    for (int k = 0; k < 20; k++) begin
      if (k < 4) begin
        address     = {10'(300 + k), 9'(20 * k + 1)};
        color       = 8'(8'hE0 + k);
        pixel_valid = 1'b1;
        e.a = lin(300 + k, 20 * k + 1);
        e.d = 8'(8'hE0 + k);
        sb.push_back(e);
      end else begin
        pixel_valid = 1'b0;
      end
      tick();
      if (mem_we === 1'b1 && !prev) begin
        nwr++;
        total++;
        if (sb.size() == 0) begin bad++; $display("FAIL b2b_extra: got write addr %0d want none", mem_addr); end
        else begin
          e = sb.pop_front();
          total++; if (mem_addr !== e.a) begin bad++; $display("FAIL b2b_addr: got %0d want %0d", mem_addr, e.a); end
          total++; if (mem_wdata !== e.d) begin bad++; $display("FAIL b2b_data: got %h want %h", mem_wdata, e.d); end
        end
        if (last >= 0) begin
          total++; if (k - last != 2) begin bad++; $display("FAIL b2b_spacing: got %0d want 2", k - last); end
        end
        last = k;
      end
      prev = mem_we;
    end
    total++; if (nwr != 4) begin bad++; $display("FAIL b2b_count: got %0d want 4", nwr); end
    total++; if (sb.size() != 0) begin bad++; $display("FAIL b2b_left: got %0d want 0", sb.size()); end
  endtask

  task automatic test_clip();
    exp_t e;
    logic prev;
    int   nwr;
    mem_ack = 1'b1;
    drive_pixel(700, 10, 8'h5C, !CLIP_ON);
    pixel_valid = 1'b0;
    prev = 1'b0;
    nwr  = 0;
    for (int k = 0; k < 10; k++) begin
      if (mem_we === 1'b1 && !prev) begin
        nwr++;
        total++;
        if (sb.size() == 0) begin bad++; $display("FAIL clip_extra: got write addr %0d want none", mem_addr); end
        else begin
          e = sb.pop_front();
          total++; if (mem_addr !== e.a) begin bad++; $display("FAIL clip_addr: got %0d want %0d", mem_addr, e.a); end
          total++; if (mem_wdata !== e.d) begin bad++; $display("FAIL clip_data: got %h want %h", mem_wdata, e.d); end
        end
      end
      prev = mem_we;
      tick();
    end
    total++; if (nwr != (CLIP_ON ? 0 : 1)) begin bad++; $display("FAIL clip_count: got %0d want %0d", nwr, (CLIP_ON ? 0 : 1)); end
    total++; if (sb.size() != 0) begin bad++; $display("FAIL clip_left: got %0d want 0", sb.size()); end
  endtask

  task automatic test_reset_mid();
    int we_cycles;
    mem_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_pixel(50 + i, 60 + i, 8'(8'h70 + i), 1'b0);
    end
    pixel_valid = 1'b0;
    total++; if (mem_we !== 1'b1) begin bad++; $display("FAIL rmid_we_pre: got %b want 1", mem_we); end
    total++; if (stop !== 1'b1) begin bad++; $display("FAIL rmid_stop_pre: got %b want 1", stop); end
    #2;
    n_rst = 1'b0;
    #1;
    total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL rmid_we: got %b want 0", mem_we); end
    total++; if (stop !== 1'b0) begin bad++; $display("FAIL rmid_stop: got %b want 0", stop); end
    sb.delete();
    tick();
    n_rst = 1'b1;
    mem_ack = 1'b1;
    we_cycles = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (mem_we === 1'b1) we_cycles++;
    end
    total++; if (we_cycles != 0) begin bad++; $display("FAIL rmid_after: got %0d writes want 0", we_cycles); end
    total++; if (stop !== 1'b0) begin bad++; $display("FAIL rmid_stop_after: got %b want 0", stop); end
    mem_ack = 1'b0;
  endtask

  initial begin
    n_rst       = 1'b0;
    address     = 19'd0;
    pixel_valid = 1'b0;
    color       = 8'd0;
    prim_done   = 1'b0;
    mem_ack     = 1'b0;
    test_reset();
    test_single();
    test_idle_done();
    test_backpressure();
    test_done_order();
    test_back_to_back();
    test_clip();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
